sa_wresp_channel: RTL and testbench
===================================

# sa_wresp_channel

Slave-side write-response router of the AXI4 interconnect. It sits between one downstream slave port and the per-master dispatchers. It records which master won each AW grant in an in-order master-ID FIFO. It accepts the slave's B beats in that same order through a one-entry output register, and presents each response to the owning master's dispatcher as a one-hot BVALID. It is the counterpart of the dispatcher B channel, which collects responses from all slave arbiters for one master.

## Interface
Parameters:
- MST_AMT, 2, number of masters / dispatchers served
- OUTSTANDING_AMT, 8, depth of the master-order FIFO, i.e. max AW grants awaiting B
- TRANS_MST_ID_W, 5, width of BID
- TRANS_WR_RESP_W, 2, width of BRESP
- MST_ID_W, $clog2(MST_AMT), width of master index

Ports (one clock; reset is asynchronous and active-high):
- ACLK_i  in  1  clock, all state on rising edge
- ARESET_i  in  1  asynchronous, active-high reset
- s_BID_i  in  TRANS_MST_ID_W  slave response ID
- s_BRESP_i  in  TRANS_WR_RESP_W  slave response code
- s_BVALID_i  in  1  slave response valid
- s_BREADY_o  out  1  ready to slave
- sa_AW_mst_id_i  in  MST_ID_W  master index of the AW grant
- sa_AW_shift_en_i  in  1  AW grant accepted this cycle (push)
- sa_AW_stall_o  out  1  order FIFO full; AW arbitration must not grant
- dsp_BID_o  out  TRANS_MST_ID_W*MST_AMT  BID to each dispatcher, lane m at [W*(m+1)-1 -: W]
- dsp_BRESP_o  out  TRANS_WR_RESP_W*MST_AMT  BRESP to each dispatcher, same packing
- dsp_BVALID_o  out  MST_AMT  one-hot response valid
- dsp_BREADY_i  in  MST_AMT  dispatcher ready

## Operation
- Order FIFO:
  - Push sa_AW_mst_id_i when sa_AW_shift_en_i=1 and the FIFO is not full.
  - A push while full is dropped. This is a caller protocol violation; the bench asserts on it.
  - sa_AW_stall_o = full.
  - Pop on every slave handshake (s_BVALID_i & s_BREADY_o).
- Output register holds out_vld, out_mst, out_id and out_resp.
- s_BREADY_o = ~ord_empty & (~out_vld | out_hs).
  - out_hs = out_vld & dsp_BREADY_i[out_mst].
  - The ready path is combinational from dsp_BREADY_i, so full throughput is supported.
- On slave handshake: load out_mst = FIFO head, out_id = s_BID_i, out_resp = s_BRESP_i; set out_vld = 1.
- On out_hs with no new slave handshake: clear out_vld. out_id and out_resp hold their last value.
- dsp_BVALID_o[m] = out_vld & (out_mst == m).
- dsp_BID_o and dsp_BRESP_o broadcast out_id / out_resp on every lane. Only the one-hot valid qualifies a lane.
- BRESP and BID pass through unmodified; no arithmetic is applied.

## Timing
- Reset values: s_BREADY_o=0, sa_AW_stall_o=0, dsp_BVALID_o=0, dsp_BID_o=0, dsp_BRESP_o=0. Order FIFO is empty.
- Latency from AW push to s_BREADY_o=1 is 1 cycle: the FIFO is registered and the head is visible the cycle after the push.
- Latency from slave handshake at edge N to dsp_BVALID_o high is 1 cycle (visible after edge N).
- Back-to-back: with a dispatcher ready every cycle, one response per cycle is sustained.
- Simultaneous out_hs and slave handshake: the register reloads with no bubble. dsp_BVALID_o may move to a different master lane in the next cycle.
- Simultaneous push and pop with the FIFO full: the push is dropped (full is evaluated pre-pop). sa_AW_stall_o prevents this case in a legal system.
- FIFO empty while s_BVALID_i=1: s_BREADY_o=0 and the slave waits.
- Reset mid-operation: all state clears asynchronously, and any in-flight response is lost. Upstream resets together.
- A dispatcher holding BREADY low stalls the slave, because no reordering or bypass is performed.

## Structure
- The shared interconnect package holds the BRESP codes (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11) and the mst-index width function.
- The order FIFO is the existing shared fifo module (DATA_WIDTH=MST_ID_W, FIFO_DEPTH=OUTSTANDING_AMT) with rst_n driven by ~ARESET_i.
- The output register and ready logic are inline.

## Test plan
- Single transaction: push mst=1. Next cycle, slave BID=5'h0A, BRESP=2'b00 with dsp_BREADY_i=2'b11. Required: dsp_BVALID_o=2'b10 for exactly one cycle, dsp_BID_o lane1=5'h0A. FIFO is then empty and s_BREADY_o=0.
- Ordering: push mst 0,1,0. Slave returns IDs 1,2,3 back-to-back with dsp_BREADY_i=2'b11. Required: dsp_BVALID_o=01,10,01 on consecutive cycles carrying IDs 1,2,3 with no bubble.
- Backpressure: push mst 0 twice, hold dsp_BREADY_i[0]=0 for 4 cycles. Required:
  - first response is held with stable BID and BRESP=2'b10;
  - s_BREADY_o=0 while out_vld is set;
  - on release, the second response follows in the next cycle.
- Full: push 8 grants without responses. Required: sa_AW_stall_o=1 after the 8th push. A 9th push is dropped and the bench flags it. After one B handshake, stall deasserts next cycle.
- Early slave valid: s_BVALID_i=1 with FIFO empty for 3 cycles, then push mst=0. Required: s_BREADY_o=0 for 4 cycles total, then 1 the cycle after the push.
- Reset: assert ARESET_i while dsp_BVALID_o=2'b01 and FIFO count is 3. Required: all outputs are 0 immediately (asynchronous), the FIFO is empty, and operation resumes normally after release.

Source files
------------

// File: rtl/sa_wresp_channel_pkg.sv
// Shared interconnect definitions for the slave-side write-response router:
// BRESP codes and the master-index width helper.
package sa_wresp_channel_pkg;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  // A single master still needs a one-bit index so ports never collapse to zero width.
  function automatic int unsigned mst_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sa_wresp_channel_fifo.sv
// Synchronous FIFO with registered head; a push while full is dropped.
// Data is visible on rd_data_o the cycle after it is written.
module sa_wresp_channel_fifo #(
  parameter int unsigned DATA_WIDTH = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  push, pop;

  assign full_o    = (cnt_q == CntW'(FIFO_DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign push      = wr_en_i & ~full_o;
  assign pop       = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/sa_wresp_channel.sv
// Slave-side B router: records AW grant owners in order and steers each slave
// B beat to the owning master's dispatcher through a one-entry output register.
module sa_wresp_channel
  import sa_wresp_channel_pkg::*;
#(
  parameter int unsigned MST_AMT         = 2,
  parameter int unsigned OUTSTANDING_AMT = 8,
  parameter int unsigned TRANS_MST_ID_W  = 5,
  parameter int unsigned TRANS_WR_RESP_W = 2,
  parameter int unsigned MST_ID_W        = mst_idx_w(MST_AMT)
) (
  input  logic                                 ACLK_i,
  input  logic                                 ARESET_i,
  input  logic [TRANS_MST_ID_W-1:0]            s_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]           s_BRESP_i,
  input  logic                                 s_BVALID_i,
  output logic                                 s_BREADY_o,
  input  logic [MST_ID_W-1:0]                  sa_AW_mst_id_i,
  input  logic                                 sa_AW_shift_en_i,
  output logic                                 sa_AW_stall_o,
  output logic [TRANS_MST_ID_W*MST_AMT-1:0]    dsp_BID_o,
  output logic [TRANS_WR_RESP_W*MST_AMT-1:0]   dsp_BRESP_o,
  output logic [MST_AMT-1:0]                   dsp_BVALID_o,
  input  logic [MST_AMT-1:0]                   dsp_BREADY_i
);

  logic                       ord_full, ord_empty;
  logic [MST_ID_W-1:0]        ord_head;
  logic                       slv_hs, out_hs;

  logic                       out_vld_q, out_vld_d;
  logic [MST_ID_W-1:0]        out_mst_q, out_mst_d;
  logic [TRANS_MST_ID_W-1:0]  out_id_q, out_id_d;
  logic [TRANS_WR_RESP_W-1:0] out_resp_q, out_resp_d;

  sa_wresp_channel_fifo #(
    .DATA_WIDTH (MST_ID_W),
    .FIFO_DEPTH (OUTSTANDING_AMT)
  ) u_order_fifo (
    .clk_i     (ACLK_i),
    .rst_ni    (~ARESET_i),
    .wr_en_i   (sa_AW_shift_en_i),
    .wr_data_i (sa_AW_mst_id_i),
    .rd_en_i   (slv_hs),
    .rd_data_o (ord_head),
    .full_o    (ord_full),
    .empty_o   (ord_empty)
  );

  assign sa_AW_stall_o = ord_full;

  // Ready is combinational from the owning dispatcher so the register can
  // drain and reload in the same cycle.
  assign out_hs     = out_vld_q & dsp_BREADY_i[out_mst_q];
  assign s_BREADY_o = ~ord_empty & (~out_vld_q | out_hs);
  assign slv_hs     = s_BVALID_i & s_BREADY_o;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_mst_d  = out_mst_q;
    out_id_d   = out_id_q;
    out_resp_d = out_resp_q;
    if (slv_hs) begin
      out_vld_d  = 1'b1;
      out_mst_d  = ord_head;
      out_id_d   = s_BID_i;
      out_resp_d = s_BRESP_i;
    end else if (out_hs) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK_i or posedge ARESET_i) begin
    if (ARESET_i) begin
      out_vld_q  <= 1'b0;
      out_mst_q  <= '0;
      out_id_q   <= '0;
      out_resp_q <= BRESP_OKAY;
    end else begin
      out_vld_q  <= out_vld_d;
      out_mst_q  <= out_mst_d;
      out_id_q   <= out_id_d;
      out_resp_q <= out_resp_d;
    end
  end

  for (genvar m = 0; m < MST_AMT; m++) begin : g_lane
    assign dsp_BVALID_o[m] = out_vld_q & (out_mst_q == MST_ID_W'(m));
  end

  assign dsp_BID_o   = {MST_AMT{out_id_q}};
  assign dsp_BRESP_o = {MST_AMT{out_resp_q}};

endmodule

// File: tb/tb_sa_wresp_channel.sv
// Directed bench for sa_wresp_channel: one task per scenario, inline checks.
module tb_sa_wresp_channel;

  logic        ACLK_i;
  logic        ARESET_i;
  logic [4:0]  s_BID_i;
  logic [1:0]  s_BRESP_i;
  logic        s_BVALID_i;
  logic        s_BREADY_o;
  logic [0:0]  sa_AW_mst_id_i;
  logic        sa_AW_shift_en_i;
  logic        sa_AW_stall_o;
  logic [9:0]  dsp_BID_o;
  logic [3:0]  dsp_BRESP_o;
  logic [1:0]  dsp_BVALID_o;
  logic [1:0]  dsp_BREADY_i;

  int n_chk  = 0;
  int n_pass = 0;
  int n_drop = 0;

  sa_wresp_channel dut (
    .ACLK_i           (ACLK_i),
    .ARESET_i         (ARESET_i),
    .s_BID_i          (s_BID_i),
    .s_BRESP_i        (s_BRESP_i),
    .s_BVALID_i       (s_BVALID_i),
    .s_BREADY_o       (s_BREADY_o),
    .sa_AW_mst_id_i   (sa_AW_mst_id_i),
    .sa_AW_shift_en_i (sa_AW_shift_en_i),
    .sa_AW_stall_o    (sa_AW_stall_o),
    .dsp_BID_o        (dsp_BID_o),
    .dsp_BRESP_o      (dsp_BRESP_o),
    .dsp_BVALID_o     (dsp_BVALID_o),
    .dsp_BREADY_i     (dsp_BREADY_i)
  );

  initial ACLK_i = 1'b0;
  always #5 ACLK_i = ~ACLK_i;

  // Protocol monitor: a grant pushed while the order FIFO is full is illegal.
  always @(posedge ACLK_i) begin
    if (!ARESET_i && sa_AW_shift_en_i && sa_AW_stall_o) begin
      n_drop++;
      $display("note: AW push while stalled at %0t (push is dropped)", $time);
    end
  end

  task automatic tick;
    @(posedge ACLK_i);
    #1;
  endtask

  task automatic test_reset;
    ARESET_i = 1'b1;
    #2;
    n_chk++; if (s_BREADY_o !== 1'b0) $display("FAIL rst_bready: got %b want 0", s_BREADY_o); else n_pass++;
    n_chk++; if (sa_AW_stall_o !== 1'b0) $display("FAIL rst_stall: got %b want 0", sa_AW_stall_o); else n_pass++;
    n_chk++; if (dsp_BVALID_o !== 2'b00) $display("FAIL rst_bvalid: got %b want 00", dsp_BVALID_o); else n_pass++;
    n_chk++; if (dsp_BID_o !== 10'h000) $display("FAIL rst_bid: got %h want 000", dsp_BID_o); else n_pass++;
    n_chk++; if (dsp_BRESP_o !== 4'h0) $display("FAIL rst_bresp: got %h want 0", dsp_BRESP_o); else n_pass++;
    tick();
    tick();
    ARESET_i = 1'b0;
    tick();
  endtask

  task automatic test_single;
    dsp_BREADY_i = 2'b11;
    sa_AW_mst_id_i = 1'b1; sa_AW_shift_en_i = 1'b1;
    tick();
    sa_AW_shift_en_i = 1'b0;
    n_chk++; if (s_BREADY_o !== 1'b1) $display("FAIL single_bready: got %b want 1", s_BREADY_o); else n_pass++;
    s_BVALID_i = 1'b1; s_BID_i = 5'h0A; s_BRESP_i = 2'b00;
    tick();
    s_BVALID_i = 1'b0;
    n_chk++; if (dsp_BVALID_o !== 2'b10) $display("FAIL single_bvalid: got %b want 10", dsp_BVALID_o); else n_pass++;
    n_chk++; if (dsp_BID_o[9:5] !== 5'h0A) $display("FAIL single_bid1: got %h want 0a", dsp_BID_o[9:5]); else n_pass++;
    n_chk++; if (dsp_BID_o !== {2{5'h0A}}) $display("FAIL single_bid_bcast: got %h want %h", dsp_BID_o, {2{5'h0A}}); else n_pass++;
    n_chk++; if (s_BREADY_o !== 1'b0) $display("FAIL single_empty_bready: got %b want 0", s_BREADY_o); else n_pass++;
    tick();
    n_chk++; if (dsp_BVALID_o !== 2'b00) $display("FAIL single_one_cycle: got %b want 00", dsp_BVALID_o); else n_pass++;
  endtask

  task automatic test_ordering;
    logic [1:0] exp_v [3];
    exp_v[0] = 2'b01; exp_v[1] = 2'b10; exp_v[2] = 2'b01;
    dsp_BREADY_i = 2'b11;
    sa_AW_shift_en_i = 1'b1;
    sa_AW_mst_id_i = 1'b0; tick();
    sa_AW_mst_id_i = 1'b1; tick();
    sa_AW_mst_id_i = 1'b0; tick();
    sa_AW_shift_en_i = 1'b0;
    s_BVALID_i = 1'b1; s_BRESP_i = 2'b01;
    for (int k = 0; k < 3; k++) begin
      s_BID_i = 5'(k + 1);
      n_chk++; if (s_BREADY_o !== 1'b1) $display("FAIL order_bready%0d: got %b want 1", k, s_BREADY_o); else n_pass++;
      tick();
      n_chk++; if (dsp_BVALID_o !== exp_v[k]) $display("FAIL order_bvalid%0d: got %b want %b", k, dsp_BVALID_o, exp_v[k]); else n_pass++;
      n_chk++; if (dsp_BID_o !== {2{5'(k + 1)}}) $display("FAIL order_bid%0d: got %h want %h", k, dsp_BID_o, {2{5'(k + 1)}}); else n_pass++;
    end
    s_BVALID_i = 1'b0;
    tick();
    n_chk++; if (dsp_BVALID_o !== 2'b00) $display("FAIL order_drain: got %b want 00", dsp_BVALID_o); else n_pass++;
  endtask

  task automatic test_backpressure;
    dsp_BREADY_i = 2'b10;
    sa_AW_mst_id_i = 1'b0; sa_AW_shift_en_i = 1'b1;
    tick();
    tick();
    sa_AW_shift_en_i = 1'b0;
    s_BVALID_i = 1'b1; s_BID_i = 5'h07; s_BRESP_i = 2'b10;
    tick();
    s_BID_i = 5'h08; s_BRESP_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      n_chk++; if (dsp_BVALID_o !== 2'b01) $display("FAIL bp_bvalid%0d: got %b want 01", i, dsp_BVALID_o); else n_pass++;
      n_chk++; if (dsp_BID_o[4:0] !== 5'h07) $display("FAIL bp_bid%0d: got %h want 07", i, dsp_BID_o[4:0]); else n_pass++;
      n_chk++; if (dsp_BRESP_o[1:0] !== 2'b10) $display("FAIL bp_bresp%0d: got %b want 10", i, dsp_BRESP_o[1:0]); else n_pass++;
      n_chk++; if (s_BREADY_o !== 1'b0) $display("FAIL bp_bready%0d: got %b want 0", i, s_BREADY_o); else n_pass++;
      tick();
    end
    dsp_BREADY_i = 2'b11;
    #1;
    n_chk++; if (s_BREADY_o !== 1'b1) $display("FAIL bp_release_bready: got %b want 1", s_BREADY_o); else n_pass++;
    tick();
    s_BVALID_i = 1'b0;
    n_chk++; if (dsp_BVALID_o !== 2'b01) $display("FAIL bp_second_bvalid: got %b want 01", dsp_BVALID_o); else n_pass++;
    n_chk++; if (dsp_BID_o[4:0] !== 5'h08) $display("FAIL bp_second_bid: got %h want 08", dsp_BID_o[4:0]); else n_pass++;
    n_chk++; if (dsp_BRESP_o[1:0] !== 2'b01) $display("FAIL bp_second_bresp: got %b want 01", dsp_BRESP_o[1:0]); else n_pass++;
    tick();
    n_chk++; if (dsp_BVALID_o !== 2'b00) $display("FAIL bp_drain: got %b want 00", dsp_BVALID_o); else n_pass++;
  endtask

  task automatic test_full;
    dsp_BREADY_i = 2'b11;
    sa_AW_shift_en_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sa_AW_mst_id_i = 1'(i % 2);
      tick();
      if (i == 6) begin
        n_chk++; if (sa_AW_stall_o !== 1'b0) $display("FAIL full_stall7: got %b want 0", sa_AW_stall_o); else n_pass++;
      end
    end
    n_chk++; if (sa_AW_stall_o !== 1'b1) $display("FAIL full_stall8: got %b want 1", sa_AW_stall_o); else n_pass++;
    sa_AW_mst_id_i = 1'b1;
    tick();
    sa_AW_shift_en_i = 1'b0;
    n_chk++; if (n_drop !== 1) $display("FAIL full_push_flagged: got %0d want 1", n_drop); else n_pass++;
    n_chk++; if (sa_AW_stall_o !== 1'b1) $display("FAIL full_stall9: got %b want 1", sa_AW_stall_o); else n_pass++;
    s_BVALID_i = 1'b1; s_BRESP_i = 2'b00;
    for (int k = 0; k < 8; k++) begin
      s_BID_i = 5'(k + 16);
      tick();
      if (k == 0) begin
        n_chk++; if (sa_AW_stall_o !== 1'b0) $display("FAIL full_unstall: got %b want 0", sa_AW_stall_o); else n_pass++;
      end
      n_chk++; if (dsp_BVALID_o !== ((k % 2 == 1) ? 2'b10 : 2'b01))
        $display("FAIL full_order%0d: got %b want %b", k, dsp_BVALID_o, (k % 2 == 1) ? 2'b10 : 2'b01);
      else n_pass++;
    end
    s_BVALID_i = 1'b0;
    n_chk++; if (s_BREADY_o !== 1'b0) $display("FAIL full_dropped_empty: got %b want 0", s_BREADY_o); else n_pass++;
    tick();
    n_chk++; if (dsp_BVALID_o !== 2'b00) $display("FAIL full_drain: got %b want 00", dsp_BVALID_o); else n_pass++;
  endtask

  task automatic test_early_valid;
    dsp_BREADY_i = 2'b11;
    s_BVALID_i = 1'b1; s_BID_i = 5'h1F; s_BRESP_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      n_chk++; if (s_BREADY_o !== 1'b0) $display("FAIL early_bready%0d: got %b want 0", i, s_BREADY_o); else n_pass++;
      tick();
    end
    sa_AW_mst_id_i = 1'b0; sa_AW_shift_en_i = 1'b1;
    n_chk++; if (s_BREADY_o !== 1'b0) $display("FAIL early_bready3: got %b want 0", s_BREADY_o); else n_pass++;
    tick();
    sa_AW_shift_en_i = 1'b0;
    n_chk++; if (s_BREADY_o !== 1'b1) $display("FAIL early_bready_push: got %b want 1", s_BREADY_o); else n_pass++;
    tick();
    s_BVALID_i = 1'b0;
    n_chk++; if (dsp_BVALID_o !== 2'b01) $display("FAIL early_bvalid: got %b want 01", dsp_BVALID_o); else n_pass++;
    n_chk++; if (dsp_BRESP_o !== 4'hF) $display("FAIL early_bresp: got %h want f", dsp_BRESP_o); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid;
    dsp_BREADY_i = 2'b00;
    sa_AW_shift_en_i = 1'b1;
    sa_AW_mst_id_i = 1'b0; tick();
    sa_AW_mst_id_i = 1'b1; tick();
    sa_AW_mst_id_i = 1'b1; tick();
    sa_AW_mst_id_i = 1'b0; tick();
    sa_AW_shift_en_i = 1'b0;
    s_BVALID_i = 1'b1; s_BID_i = 5'h05; s_BRESP_i = 2'b11;
    tick();
    s_BVALID_i = 1'b0;
    n_chk++; if (dsp_BVALID_o !== 2'b01) $display("FAIL rmid_pre_bvalid: got %b want 01", dsp_BVALID_o); else n_pass++;
    #2;
    ARESET_i = 1'b1;
    #1;
    n_chk++; if (dsp_BVALID_o !== 2'b00) $display("FAIL rmid_bvalid: got %b want 00", dsp_BVALID_o); else n_pass++;
    n_chk++; if (dsp_BID_o !== 10'h000) $display("FAIL rmid_bid: got %h want 000", dsp_BID_o); else n_pass++;
    n_chk++; if (dsp_BRESP_o !== 4'h0) $display("FAIL rmid_bresp: got %h want 0", dsp_BRESP_o); else n_pass++;
    n_chk++; if (s_BREADY_o !== 1'b0) $display("FAIL rmid_bready: got %b want 0", s_BREADY_o); else n_pass++;
    tick();
    ARESET_i = 1'b0;
    tick();
    dsp_BREADY_i = 2'b11;
    #1;
    n_chk++; if (s_BREADY_o !== 1'b0) $display("FAIL rmid_fifo_empty: got %b want 0", s_BREADY_o); else n_pass++;
    sa_AW_mst_id_i = 1'b1; sa_AW_shift_en_i = 1'b1;
    tick();
    sa_AW_shift_en_i = 1'b0;
    s_BVALID_i = 1'b1; s_BID_i = 5'h15; s_BRESP_i = 2'b01;
    n_chk++; if (s_BREADY_o !== 1'b1) $display("FAIL rmid_resume_bready: got %b want 1", s_BREADY_o); else n_pass++;
    tick();
    s_BVALID_i = 1'b0;
    n_chk++; if (dsp_BVALID_o !== 2'b10) $display("FAIL rmid_resume_bvalid: got %b want 10", dsp_BVALID_o); else n_pass++;
    n_chk++; if (dsp_BID_o[9:5] !== 5'h15) $display("FAIL rmid_resume_bid: got %h want 15", dsp_BID_o[9:5]); else n_pass++;
    n_chk++; if (dsp_BRESP_o[3:2] !== 2'b01) $display("FAIL rmid_resume_bresp: got %b want 01", dsp_BRESP_o[3:2]); else n_pass++;
    tick();
  endtask

  initial begin
    ARESET_i         = 1'b0;
    s_BID_i          = '0;
    s_BRESP_i        = '0;
    s_BVALID_i       = 1'b0;
    sa_AW_mst_id_i   = '0;
    sa_AW_shift_en_i = 1'b0;
    dsp_BREADY_i     = '0;
    #1;
    test_reset();
    test_single();
    test_ordering();
    test_backpressure();
    test_full();
    test_early_valid();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
